reaction_round_sequencer: RTL

//   Sequences the perception-timer datapath through NUM_ROUNDS reaction rounds: random

---
 rtl/reaction_round_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/reaction_round_sequencer.sv
// reaction_round_sequencer
//   Runs a session of NUM_ROUNDS reaction rounds: random hold-off, button
//   prompt, millisecond reaction timing and result capture, with best-time
//   tracking across the session.
//   Build macro SEQ_PENALTY_EN: when defined, a wrong button in PROMPT adds
//   PENALTY_MS to the running time and the round continues; when undefined,
//   a wrong button ends the round with a timeout-valued result.
//   All millisecond arithmetic (hold-off, reaction time, penalty) clamps at
//   TIMEOUT_MS.
module reaction_round_sequencer #(
  parameter int TICKS_PER_MS = 50000,
  parameter int NUM_ROUNDS   = 4,
  parameter int MIN_DELAY_MS = 1000,
`ifdef SEQ_PENALTY_EN
  parameter int PENALTY_MS   = 500,
`endif
  parameter int TIMEOUT_MS   = 9999
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic        iChooseRandID,
  input  logic [2:0]  iButtonsPressed,
  output logic [1:0]  oButtonReq,
  output logic        oPromptValid,
  output logic        oTimerRun,
  output logic        oTimerClear,
  output logic [3:0]  oRoundIdx,
  output logic        oResultValid,
  output logic [13:0] oResultMs,
  output logic [13:0] oBestMs,
  output logic [1:0]  oErrorCode,
  output logic        oBusy,
  output logic        oDone
);

  localparam int              TICK_W      = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_MS - 1);
  localparam logic [13:0]     TIMEOUT_V   = 14'(TIMEOUT_MS);
  localparam logic [14:0]     MIN_DELAY_V = 15'(MIN_DELAY_MS);
  localparam logic [3:0]      LAST_ROUND  = 4'(NUM_ROUNDS - 1);
  localparam logic [15:0]     LFSR_SEED   = 16'hACE1;
  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right
  localparam logic [15:0]     LFSR_TAPS   = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_PROMPT,
    S_RESULT,
    S_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [15:0]         lfsr_reg;
  logic [2:0]          btn_prev_reg;
  logic                start_prev_reg;
  logic [TICK_W-1:0]   tick_cnt_reg;
  logic [13:0]         delay_reg;
  logic [13:0]         ms_cnt_reg;
  logic [1:0]          id_reg;
  logic [1:0]          cyc_id_reg;
  logic [3:0]          round_reg;
  logic [13:0]         result_ms_reg;
  logic [13:0]         best_ms_reg;
  logic [1:0]          err_reg;
  logic                result_valid_reg;
  logic                timer_clear_reg;
`ifdef SEQ_PENALTY_EN
  logic                penalty_hit_reg;
  logic                penalty_press;
  logic [13:0]         ms_pen;
`endif

  // Decoded events and control strobes
  logic [2:0]  btn_rise;
  logic        any_press;
  logic        start_rise;
  logic        ms_tick;
  logic [2:0]  req_mask;
  logic        correct_press;
  logic [13:0] delay_load;
  logic [13:0] ms_step;
  logic [1:0]  rand_id;
  logic        start_session;
  logic        load_delay;
  logic        false_start;
  logic        enter_prompt;
  logic        capture;
  logic [13:0] cap_ms;
  logic [1:0]  cap_err;
  logic        round_inc;

  // Clamp a 15-bit millisecond sum to TIMEOUT_MS so nothing ever wraps
  function automatic logic [13:0] sat_ms(input logic [14:0] v);
    if (v > {1'b0, TIMEOUT_V}) begin
      return TIMEOUT_V;
    end
    return v[13:0];
  endfunction

  // Edge detection, tick decode and datapath arithmetic
  always_comb begin
    btn_rise      = iButtonsPressed & ~btn_prev_reg;
    any_press     = |btn_rise;
    start_rise    = iStart & ~start_prev_reg;
    ms_tick       = (tick_cnt_reg == TICK_LAST);
    req_mask      = 3'b000;
    case (id_reg)
      2'd1:    req_mask = 3'b001;
      2'd2:    req_mask = 3'b010;
      2'd3:    req_mask = 3'b100;
      default: req_mask = 3'b000;
    endcase
    // a second button rising in the same cycle makes this a wrong press
    correct_press = (btn_rise == req_mask);
    delay_load    = sat_ms(MIN_DELAY_V + {4'd0, lfsr_reg[10:0]});
    ms_step       = sat_ms({1'b0, ms_cnt_reg} + {14'd0, ms_tick});
    rand_id       = (lfsr_reg[1:0] == 2'd0) ? 2'd1 : lfsr_reg[1:0];
`ifdef SEQ_PENALTY_EN
    ms_pen        = sat_ms({1'b0, ms_step} + 15'(PENALTY_MS));
`endif
  end

  // State register
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and per-transition control strobes
  always_comb begin
    state_next    = state_reg;
    start_session = 1'b0;
    load_delay    = 1'b0;
    false_start   = 1'b0;
    enter_prompt  = 1'b0;
    capture       = 1'b0;
    cap_ms        = ms_cnt_reg;
    cap_err       = 2'd0;
    round_inc     = 1'b0;
`ifdef SEQ_PENALTY_EN
    penalty_press = 1'b0;
`endif
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start_rise) begin
          state_next    = S_HOLD;
          start_session = 1'b1;
          load_delay    = 1'b1;
        end
      end
      S_HOLD: begin
        if (any_press) begin
          // false start: reload the hold-off, the round is not consumed
          false_start = 1'b1;
          load_delay  = 1'b1;
        end else if (ms_tick && (delay_reg <= 14'd1)) begin
          state_next   = S_PROMPT;
          enter_prompt = 1'b1;
        end
      end
      S_PROMPT: begin
        if (any_press && correct_press) begin
          state_next = S_RESULT;
          capture    = 1'b1;
          cap_ms     = ms_cnt_reg;
`ifdef SEQ_PENALTY_EN
          cap_err    = penalty_hit_reg ? 2'd1 : 2'd0;
`else
          cap_err    = 2'd0;
`endif
        end else if (any_press) begin
`ifdef SEQ_PENALTY_EN
          penalty_press = 1'b1;
`else
          state_next = S_RESULT;
          capture    = 1'b1;
          cap_ms     = TIMEOUT_V;
          cap_err    = 2'd1;
`endif
        end else if (ms_cnt_reg >= TIMEOUT_V) begin
          state_next = S_RESULT;
          capture    = 1'b1;
          cap_ms     = TIMEOUT_V;
          cap_err    = 2'd3;
        end
      end
      S_RESULT: begin
        if (round_reg == LAST_ROUND) begin
          state_next = S_DONE;
        end else begin
          state_next = S_HOLD;
          round_inc  = 1'b1;
          load_delay = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Free-running LFSR and input edge-detect history
  always_ff @(posedge iClk) begin
    if (iRst) begin
      lfsr_reg       <= LFSR_SEED;
      btn_prev_reg   <= 3'b000;
      start_prev_reg <= 1'b0;
    end else begin
      lfsr_reg       <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);
      btn_prev_reg   <= iButtonsPressed;
      start_prev_reg <= iStart;
    end
  end

  // Millisecond prescaler, restarted on every state entry and hold reload
  always_ff @(posedge iClk) begin
    if (iRst) begin
      tick_cnt_reg <= '0;
    end else if ((state_next != state_reg) || false_start || ms_tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
    end
  end

  // Hold-off countdown and reaction-time counter
  always_ff @(posedge iClk) begin
    if (iRst) begin
      delay_reg  <= 14'd0;
      ms_cnt_reg <= 14'd0;
    end else begin
      if (load_delay) begin
        delay_reg <= delay_load;
      end else if ((state_reg == S_HOLD) && ms_tick && (delay_reg != 14'd0)) begin
        delay_reg <= delay_reg - 14'd1;
      end
      if (enter_prompt) begin
        ms_cnt_reg <= 14'd0;
      end else if (state_reg == S_PROMPT) begin
`ifdef SEQ_PENALTY_EN
        ms_cnt_reg <= penalty_press ? ms_pen : ms_step;
`else
        ms_cnt_reg <= ms_step;
`endif
      end
    end
  end

  // Prompt ID selection and round bookkeeping
  always_ff @(posedge iClk) begin
    if (iRst) begin
      id_reg     <= 2'd1;
      cyc_id_reg <= 2'd1;
      round_reg  <= 4'd0;
    end else begin
      if (start_session) begin
        cyc_id_reg <= 2'd1;
        round_reg  <= 4'd0;
      end else begin
        if (enter_prompt) begin
          id_reg     <= iChooseRandID ? rand_id : cyc_id_reg;
          cyc_id_reg <= (cyc_id_reg == 2'd3) ? 2'd1 : cyc_id_reg + 2'd1;
        end
        if (round_inc) begin
          round_reg <= round_reg + 4'd1;
        end
      end
    end
  end

  // Result capture, best time, error code and one-cycle pulses
  always_ff @(posedge iClk) begin
    if (iRst) begin
      result_ms_reg    <= 14'd0;
      best_ms_reg      <= TIMEOUT_V;
      err_reg          <= 2'd0;
      result_valid_reg <= 1'b0;
      timer_clear_reg  <= 1'b0;
`ifdef SEQ_PENALTY_EN
      penalty_hit_reg  <= 1'b0;
`endif
    end else begin
      result_valid_reg <= capture;
      timer_clear_reg  <= enter_prompt;
      if (start_session) begin
        best_ms_reg <= TIMEOUT_V;
        err_reg     <= 2'd0;
      end else if (capture) begin
        result_ms_reg <= cap_ms;
        best_ms_reg   <= (cap_ms < best_ms_reg) ? cap_ms : best_ms_reg;
        err_reg       <= cap_err;
      end else if (false_start) begin
        err_reg <= 2'd2;
      end
`ifdef SEQ_PENALTY_EN
      else if (penalty_press) begin
        err_reg <= 2'd1;
      end
      if (enter_prompt) begin
        penalty_hit_reg <= 1'b0;
      end else if (penalty_press) begin
        penalty_hit_reg <= 1'b1;
      end
`endif
    end
  end

  // Output decode
  always_comb begin
    oPromptValid = (state_reg == S_PROMPT);
    oTimerRun    = (state_reg == S_PROMPT);
    oButtonReq   = (state_reg == S_PROMPT) ? id_reg : 2'd0;
    oTimerClear  = timer_clear_reg;
    oRoundIdx    = round_reg;
    oResultValid = result_valid_reg;
    oResultMs    = result_ms_reg;
    oBestMs      = best_ms_reg;
    oErrorCode   = err_reg;
    oBusy        = (state_reg == S_HOLD) || (state_reg == S_PROMPT) || (state_reg == S_RESULT);
    oDone        = (state_reg == S_DONE);
  end

endmodule
